instr_trace_buffer: RTL and testbench

Synthesisable, parametrised instruction-trace capture unit for the RV32I core. It replaces the per-cycle PC/instruction printout with an on-chip circular buffer. The buffer records {cycle stamp, PC, instruction} for every retired instruction. It stops on a PC-match or forced trigger after a programmable number of post-trigger entries, then drains oldest-first over a valid/ready port. It sits beside `top` and taps the `pc` and `instruction` nets; a debug host or bench reads it out.

---
 rtl/trace_pkg.sv | 30 +++
 rtl/trace_ram.sv | 35 +++
 rtl/instr_trace_buffer.sv | 182 ++++++++++++++++++
 tb/tb_instr_trace_buffer.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/trace_pkg.sv
// Shared types for the instruction trace buffer: FSM state encoding and
// the layout of one trace entry {cycle, pc, instr}, most significant first.
package trace_pkg;

    // Capture FSM states; encoding is visible on state_o.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_POST  = 2'd2,
        ST_DONE  = 2'd3
    } trace_state_e;

    // Default field widths for the RV32I core.
    localparam int TRACE_XLEN = 32;
    localparam int TRACE_CYCW = 32;

    // Entry view at default widths; the RTL stores a flat word with the
    // same field order so that it stays parametrisable.
    typedef struct packed {
        logic [TRACE_CYCW-1:0] cycle;
        logic [TRACE_XLEN-1:0] pc;
        logic [TRACE_XLEN-1:0] instr;
    } trace_entry_t;

    // Width of one stored entry for arbitrary field widths.
    function automatic int entry_width(input int xlen, input int cycw);
        return cycw + 2 * xlen;
    endfunction

endpackage

// File: rtl/trace_ram.sv
// Trace storage: DEPTH x W register file, one write port, one registered
// read port. A read of the address being written returns the new data so
// the final (trigger-side) write can be shown on the very next cycle.
module trace_ram #(
    parameter int W     = 96,
    parameter int DEPTH = 16,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [W-1:0]  wdata,
    input  logic [AW-1:0] raddr,
    output logic [W-1:0]  rdata
);

    logic [W-1:0] mem [DEPTH];

    // Write port; payload needs no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Registered read with write-first bypass on address collision.
    always_ff @(posedge clk) begin
        if (we && (waddr == raddr)) begin
            rdata <= wdata;
        end else begin
            rdata <= mem[raddr];
        end
    end

endmodule

// File: rtl/instr_trace_buffer.sv
// Instruction trace capture unit: records {cycle, pc, instr} for every
// retired instruction into a circular buffer, stops a programmable number
// of entries after a PC-match or forced trigger, then drains oldest-first
// over a valid/ready port.
module instr_trace_buffer
    import trace_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int DEPTH = 16,
    parameter int CYCW  = 32,
    localparam int PTRW = $clog2(DEPTH)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            valid_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [XLEN-1:0] instr_i,
    input  logic            arm_i,
    input  logic            clear_i,
    input  logic [XLEN-1:0] trig_pc_i,
    input  logic            trig_en_i,
    input  logic            force_trig_i,
    input  logic [PTRW-1:0] post_cnt_i,
    output logic            rd_valid_o,
    input  logic            rd_ready_i,
    output logic [XLEN-1:0] rd_pc_o,
    output logic [XLEN-1:0] rd_instr_o,
    output logic [CYCW-1:0] rd_cycle_o,
    output logic [1:0]      state_o,
    output logic [PTRW:0]   count_o,
    output logic            wrapped_o
);

    localparam int            EW   = entry_width(XLEN, CYCW);
    localparam logic [PTRW:0] FULL = (PTRW+1)'(DEPTH);

    trace_state_e    state_reg,     state_next;
    logic [PTRW-1:0] wr_ptr_reg,    wr_ptr_next;
    logic [PTRW-1:0] rd_ptr_reg,    rd_ptr_next;
    logic [PTRW:0]   count_reg,     count_next;
    logic [PTRW-1:0] post_cnt_reg,  post_cnt_next;
    logic [PTRW-1:0] remaining_reg, remaining_next;
    logic            wrapped_reg,   wrapped_next;
    logic [CYCW-1:0] cycle_reg;

    logic            we;
    logic            trig;
    logic            pop;
    logic            rd_valid;
    logic [EW-1:0]   wdata;
    logic [EW-1:0]   rdata;

    assign trig     = valid_i & ((trig_en_i & (pc_i == trig_pc_i)) | force_trig_i);
    assign rd_valid = (state_reg == ST_DONE) && (count_reg != '0);
    assign pop      = rd_valid & rd_ready_i;
    assign wdata    = {cycle_reg, pc_i, instr_i};

    // Read address is the pointer value of the coming cycle, so the
    // registered RAM output lines up with rd_ptr_reg without extra latency.
    trace_ram #(
        .W     (EW),
        .DEPTH (DEPTH)
    ) u_ram (
        .clk   (clk),
        .we    (we),
        .waddr (wr_ptr_reg),
        .wdata (wdata),
        .raddr (rd_ptr_next),
        .rdata (rdata)
    );

    // Free-running cycle stamp, independent of capture state.
    always_ff @(posedge clk) begin
        if (rst) begin
            cycle_reg <= '0;
        end else begin
            cycle_reg <= cycle_reg + 1'b1;
        end
    end

    // Control state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            wr_ptr_reg    <= '0;
            rd_ptr_reg    <= '0;
            count_reg     <= '0;
            post_cnt_reg  <= '0;
            remaining_reg <= '0;
            wrapped_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            wr_ptr_reg    <= wr_ptr_next;
            rd_ptr_reg    <= rd_ptr_next;
            count_reg     <= count_next;
            post_cnt_reg  <= post_cnt_next;
            remaining_reg <= remaining_next;
            wrapped_reg   <= wrapped_next;
        end
    end

    // Next-state logic: arm, capture, trigger countdown and readout.
    always_comb begin
        state_next     = state_reg;
        wr_ptr_next    = wr_ptr_reg;
        rd_ptr_next    = rd_ptr_reg;
        count_next     = count_reg;
        post_cnt_next  = post_cnt_reg;
        remaining_next = remaining_reg;
        wrapped_next   = wrapped_reg;
        we             = 1'b0;

        if (clear_i) begin
            state_next = ST_IDLE;
            count_next = '0;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (arm_i) begin
                        post_cnt_next = post_cnt_i;
                        count_next    = '0;
                        wrapped_next  = 1'b0;
                        wr_ptr_next   = '0;
                        state_next    = ST_ARMED;
                    end
                end
                ST_ARMED, ST_POST: begin
                    if (valid_i) begin
                        we          = 1'b1;
                        wr_ptr_next = wr_ptr_reg + 1'b1;
                        if (count_reg == FULL) begin
                            wrapped_next = 1'b1;
                        end else begin
                            count_next = count_reg + 1'b1;
                        end
                        if (state_reg == ST_ARMED) begin
                            if (trig) begin
                                if (post_cnt_reg == '0) begin
                                    state_next = ST_DONE;
                                end else begin
                                    remaining_next = post_cnt_reg;
                                    state_next     = ST_POST;
                                end
                            end
                        end else begin
                            remaining_next = remaining_reg - 1'b1;
                            if (remaining_reg == PTRW'(1)) begin
                                state_next = ST_DONE;
                            end
                        end
                    end
                end
                ST_DONE: begin
                    if (count_reg == '0) begin
                        state_next = ST_IDLE;
                    end else if (pop) begin
                        rd_ptr_next = rd_ptr_reg + 1'b1;
                        count_next  = count_reg - 1'b1;
                        if (count_reg == (PTRW+1)'(1)) begin
                            state_next = ST_IDLE;
                        end
                    end
                end
                default: state_next = ST_IDLE;
            endcase
        end

        // Entering DONE: point the reader at the oldest held entry.
        if ((state_next == ST_DONE) && (state_reg != ST_DONE)) begin
            rd_ptr_next = wr_ptr_next - count_next[PTRW-1:0];
        end
    end

    assign rd_valid_o = rd_valid;
    assign rd_cycle_o = rd_valid ? rdata[EW-1:2*XLEN]     : '0;
    assign rd_pc_o    = rd_valid ? rdata[2*XLEN-1:XLEN]   : '0;
    assign rd_instr_o = rd_valid ? rdata[XLEN-1:0]        : '0;
    assign state_o    = state_reg;
    assign count_o    = count_reg;
    assign wrapped_o  = wrapped_reg;

endmodule

// File: tb/tb_instr_trace_buffer.sv
// Directed bench for instr_trace_buffer: capture, wrap, forced trigger,
// gaps with backpressure, clear mid-readout and reset mid-capture.
module tb_instr_trace_buffer;
    import trace_pkg::*;

    localparam int XLEN  = 32;
    localparam int DEPTH = 16;
    localparam int CYCW  = 32;
    localparam int PTRW  = 4;

    logic            clk = 1'b0;
    logic            rst;
    logic            valid_i;
    logic [XLEN-1:0] pc_i;
    logic [XLEN-1:0] instr_i;
    logic            arm_i;
    logic            clear_i;
    logic [XLEN-1:0] trig_pc_i;
    logic            trig_en_i;
    logic            force_trig_i;
    logic [PTRW-1:0] post_cnt_i;
    logic            rd_valid_o;
    logic            rd_ready_i;
    logic [XLEN-1:0] rd_pc_o;
    logic [XLEN-1:0] rd_instr_o;
    logic [CYCW-1:0] rd_cycle_o;
    logic [1:0]      state_o;
    logic [PTRW:0]   count_o;
    logic            wrapped_o;

    int total = 0;
    int bad   = 0;

    // Expected cycle stamp: counts clock edges since reset release.
    logic [CYCW-1:0] cyc;
    trace_entry_t    q[$];

    instr_trace_buffer #(
        .XLEN  (XLEN),
        .DEPTH (DEPTH),
        .CYCW  (CYCW)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .pc_i         (pc_i),
        .instr_i      (instr_i),
        .arm_i        (arm_i),
        .clear_i      (clear_i),
        .trig_pc_i    (trig_pc_i),
        .trig_en_i    (trig_en_i),
        .force_trig_i (force_trig_i),
        .post_cnt_i   (post_cnt_i),
        .rd_valid_o   (rd_valid_o),
        .rd_ready_i   (rd_ready_i),
        .rd_pc_o      (rd_pc_o),
        .rd_instr_o   (rd_instr_o),
        .rd_cycle_o   (rd_cycle_o),
        .state_o      (state_o),
        .count_o      (count_o),
        .wrapped_o    (wrapped_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (rst) cyc <= '0;
        else     cyc <= cyc + 1'b1;
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic arm(input logic [PTRW-1:0] post, input logic en, input logic [XLEN-1:0] tpc);
        post_cnt_i = post;
        trig_en_i  = en;
        trig_pc_i  = tpc;
        arm_i      = 1'b1;
        tick();
        arm_i      = 1'b0;
        check("arm_state", state_o, 1);
        check("arm_count", count_o, 0);
        check("arm_wrapped", wrapped_o, 0);
    endtask

    // Retire PCs 0,4,8,... on every gap-th cycle until DONE or the cycle bound.
    task automatic stream(input int gap, input logic [XLEN-1:0] force_pc, input logic keep_arm);
        int n;
        trace_entry_t e;
        n = 0;
        q.delete();
        for (int c = 0; c < 200; c++) begin
            arm_i = keep_arm;
            if ((c % gap) == 0) begin
                valid_i      = 1'b1;
                pc_i         = 32'(n * 4);
                instr_i      = 32'hA500_0000 | 32'(n);
                force_trig_i = (pc_i == force_pc);
                e.cycle = cyc;
                e.pc    = pc_i;
                e.instr = instr_i;
                q.push_back(e);
                n++;
            end else begin
                valid_i      = 1'b0;
                force_trig_i = 1'b0;
            end
            tick();
            if (state_o == 2'd3) break;
        end
        valid_i      = 1'b0;
        force_trig_i = 1'b0;
        arm_i        = 1'b0;
        check("reach_done", state_o, 3);
    endtask

    // Pop entries k0..k1-1 of the last held entries, checking each one.
    task automatic drain(input int held, input int k0, input int k1);
        int idx;
        for (int k = k0; k < k1; k++) begin
            idx = q.size() - held + k;
            check("rd_valid", rd_valid_o, 1);
            check("rd_pc", rd_pc_o, q[idx].pc);
            check("rd_instr", rd_instr_o, q[idx].instr);
            check("rd_cycle", rd_cycle_o, q[idx].cycle);
            rd_ready_i = 1'b1;
            tick();
            rd_ready_i = 1'b0;
        end
    endtask

    task automatic check_idle_after_drain();
        check("end_state", state_o, 0);
        check("end_rd_valid", rd_valid_o, 0);
        check("end_count", count_o, 0);
        check("end_rd_pc", rd_pc_o, 0);
    endtask

    initial begin
        logic [CYCW-1:0] first_stamp;
        rst = 1'b1; valid_i = 0; pc_i = 0; instr_i = 0; arm_i = 0; clear_i = 0;
        trig_pc_i = 0; trig_en_i = 0; force_trig_i = 0; post_cnt_i = 0; rd_ready_i = 0;
        tick(); tick();
        rst = 1'b0;
        check("rst_state", state_o, 0);
        check("rst_count", count_o, 0);
        check("rst_rd_valid", rd_valid_o, 0);
        check("rst_wrapped", wrapped_o, 0);

        // Basic capture: trigger at 0x20, three post entries.
        arm(4'd3, 1'b1, 32'h20);
        stream(1, 32'hFFFF_FFFF, 1'b0);
        check("basic_count", count_o, 12);
        check("basic_wrapped", wrapped_o, 0);
        check("basic_last_pc", q[q.size()-1].pc, 32'h2C);
        check("basic_first_pc", rd_pc_o, 32'h00);
        drain(12, 0, 12);
        check_idle_after_drain();

        // Wrap-around: trigger at 0x80, four post entries.
        arm(4'd4, 1'b1, 32'h80);
        stream(1, 32'hFFFF_FFFF, 1'b0);
        check("wrap_count", count_o, 16);
        check("wrap_wrapped", wrapped_o, 1);
        check("wrap_oldest_pc", rd_pc_o, 32'h54);
        drain(16, 0, 16);
        check_idle_after_drain();

        // Forced trigger, zero post; a force without valid must do nothing.
        arm(4'd0, 1'b0, 32'h0);
        force_trig_i = 1'b1;
        tick();
        force_trig_i = 1'b0;
        check("force_novalid_state", state_o, 1);
        check("force_novalid_count", count_o, 0);
        stream(1, 32'h10, 1'b0);
        check("force_count", count_o, 5);
        drain(5, 0, 5);
        check("force_last_pc", q[q.size()-1].pc, 32'h10);
        check_idle_after_drain();

        // Gaps and backpressure: valid every other cycle.
        arm(4'd2, 1'b1, 32'h0C);
        stream(2, 32'hFFFF_FFFF, 1'b0);
        check("gap_count", count_o, 6);
        for (int i = 0; i < 5; i++) begin
            tick();
            check("hold_pc", rd_pc_o, 32'h00);
            check("hold_count", count_o, 6);
        end
        first_stamp = rd_cycle_o;
        drain(6, 0, 1);
        check("gap_stamp_delta", rd_cycle_o - first_stamp, 2);
        drain(6, 1, 6);
        check_idle_after_drain();

        // Arm pulses outside IDLE are ignored; clear mid-readout wins over arm.
        arm(4'd3, 1'b1, 32'h20);
        post_cnt_i = 4'd0;
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        check("arm_in_armed", state_o, 1);
        stream(1, 32'hFFFF_FFFF, 1'b1);
        check("rearm_count", count_o, 12);
        arm_i = 1'b1;
        tick();
        arm_i = 1'b0;
        check("arm_in_done_state", state_o, 3);
        check("arm_in_done_count", count_o, 12);
        drain(12, 0, 3);
        check("after3_pc", rd_pc_o, 32'h0C);
        clear_i = 1'b1;
        arm_i   = 1'b1;
        tick();
        clear_i = 1'b0;
        arm_i   = 1'b0;
        check("clear_state", state_o, 0);
        check("clear_rd_valid", rd_valid_o, 0);
        check("clear_count", count_o, 0);
        check("clear_rd_pc", rd_pc_o, 0);
        tick();
        check("clear_beats_arm", state_o, 0);

        // Reset mid-capture after the buffer has wrapped.
        arm(4'd0, 1'b0, 32'h0);
        for (int i = 0; i < 20; i++) begin
            valid_i = 1'b1;
            pc_i    = 32'(i * 4);
            instr_i = 32'h1300_0000 | 32'(i);
            tick();
        end
        valid_i = 1'b0;
        check("pre_rst_count", count_o, 16);
        check("pre_rst_wrapped", wrapped_o, 1);
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        check("mid_rst_state", state_o, 0);
        check("mid_rst_count", count_o, 0);
        check("mid_rst_rd_valid", rd_valid_o, 0);
        check("mid_rst_rd_pc", rd_pc_o, 0);
        check("mid_rst_wrapped", wrapped_o, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
